// File: rtl/eager_fork_if.sv
// Handshake bundle between an upstream producer and the fork branches.
// The fork controller takes the slave view; the driving environment takes the master view.
interface eager_fork_if #(
    parameter int NUM_OUTPUTS = 2
);
    logic                   valid_in_i;
    logic                   ready_in_o;
    logic [NUM_OUTPUTS-1:0] valids_out_o;
    logic [NUM_OUTPUTS-1:0] readys_out_i;

    modport slave (
        input  valid_in_i,
        input  readys_out_i,
        output ready_in_o,
        output valids_out_o
    );

    modport master (
        output valid_in_i,
        output readys_out_i,
        input  ready_in_o,
        input  valids_out_o
    );
endinterface

// File: rtl/eager_fork_ctrl.sv
// Eager fork: offers each upstream token to every enabled branch at once, remembers which
// branches have taken it, and retires the token when the last enabled branch accepts.
module eager_fork_ctrl #(
    parameter int NUM_OUTPUTS = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   cfg_en_i,
    input  logic [NUM_OUTPUTS-1:0] fork_mask_i,
    eager_fork_if.slave            bus,
    output logic [NUM_OUTPUTS-1:0] pending_o,
    output logic [CNT_W-1:0]       token_cnt_o
);

    logic [NUM_OUTPUTS-1:0] mask_q,   mask_d;
    logic [NUM_OUTPUTS-1:0] served_q, served_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;

    logic [NUM_OUTPUTS-1:0] done;
    logic [NUM_OUTPUTS-1:0] valids_out;
    logic                   ready_in;
    logic                   transfer;

    // A branch no longer blocks retirement once it is disabled, already served, or ready now.
    assign done       = ~mask_q | served_q | bus.readys_out_i;
    assign ready_in   = &done;
    assign valids_out = {NUM_OUTPUTS{bus.valid_in_i}} & mask_q & ~served_q;
    assign transfer   = bus.valid_in_i & ready_in;

    assign bus.ready_in_o   = ready_in;
    assign bus.valids_out_o = valids_out;
    assign pending_o        = served_q;
    assign token_cnt_o      = cnt_q;

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can infer a latch.
        mask_d   = mask_q;
        served_d = served_q;
        cnt_d    = cnt_q;

        if (transfer) begin
            served_d = '0;
            if (|mask_q) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (bus.valid_in_i) begin
            served_d = served_q | (valids_out & bus.readys_out_i);
        end

        // The handshake above used the old mask; a new mask starts a fresh token.
        if (cfg_en_i) begin
            mask_d   = fork_mask_i;
            served_d = '0;
        end

        if (clr_i) begin
            served_d = '0;
            cnt_d    = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q   <= '0;
            served_q <= '0;
            cnt_q    <= '0;
        end else begin
            mask_q   <= mask_d;
            served_q <= served_d;
            cnt_q    <= cnt_d;
        end
    end

    a_no_double_offer: assert property (@(posedge clk_i) disable iff (rst_i)
        (valids_out & served_q) == '0);

endmodule

// File: tb/tb_eager_fork_ctrl.sv
// Self-checking bench for eager_fork_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural token model.
module tb_eager_fork_ctrl;
    localparam int N     = 2;
    localparam int CNT_W = 16;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           clr_i;
    logic           cfg_en_i;
    logic [N-1:0]   fork_mask_i;
    logic [N-1:0]   pending_o;
    logic [CNT_W-1:0] token_cnt_o;

    eager_fork_if #(.NUM_OUTPUTS(N)) bus ();

    eager_fork_ctrl #(.NUM_OUTPUTS(N), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (clr_i),
        .cfg_en_i    (cfg_en_i),
        .fork_mask_i (fork_mask_i),
        .bus         (bus),
        .pending_o   (pending_o),
        .token_cnt_o (token_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // Behavioural model: which branches hold the current token, the mask and a token count.
    logic [N-1:0] m_mask;
    logic [N-1:0] m_served;
    int unsigned  m_cnt;

    function automatic bit exp_valid(input int i);
        return bus.valid_in_i && m_mask[i] && !m_served[i];
    endfunction

    function automatic bit exp_ready();
        for (int i = 0; i < N; i++)
            if (m_mask[i] && !m_served[i] && !bus.readys_out_i[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [N-1:0] exp_valids();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = exp_valid(i);
        return v;
    endfunction

    function automatic logic [N-1:0] next_served();
        logic [N-1:0] r;
        if (clr_i || cfg_en_i) return '0;
        if (!bus.valid_in_i) return m_served;
        if (exp_ready()) return '0;
        r = m_served;
        for (int i = 0; i < N; i++)
            if (exp_valid(i) && bus.readys_out_i[i]) r[i] = 1'b1;
        return r;
    endfunction

    function automatic int unsigned next_cnt();
        if (clr_i) return 0;
        if (bus.valid_in_i && exp_ready() && m_mask != '0) return (m_cnt + 1) % (1 << CNT_W);
        return m_cnt;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_mask   <= '0;
            m_served <= '0;
            m_cnt    <= 0;
        end else begin
            m_mask   <= cfg_en_i ? fork_mask_i : m_mask;
            m_served <= next_served();
            m_cnt    <= next_cnt();
        end
    end

    always @(negedge clk_i) begin
        check("ready_in",   32'(bus.ready_in_o),   32'(exp_ready()));
        check("valids_out", 32'(bus.valids_out_o), 32'(exp_valids()));
        check("pending",    32'(pending_o),        32'(m_served));
        check("token_cnt",  32'(token_cnt_o),      m_cnt);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] r);
        bus.valid_in_i   = v;
        bus.readys_out_i = r;
    endtask

    task automatic load_mask(input logic [N-1:0] m);
        drive(1'b0, '0);
        cfg_en_i    = 1'b1;
        fork_mask_i = m;
        tick();
        cfg_en_i    = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; clr_i = 1'b0; cfg_en_i = 1'b0; fork_mask_i = '0;
        drive(1'b0, '0);
        #3;
        check("rst ready_in",  32'(bus.ready_in_o),   32'd1);
        check("rst valids",    32'(bus.valids_out_o), 32'd0);
        check("rst pending",   32'(pending_o),        32'd0);
        check("rst cnt",       32'(token_cnt_o),      32'd0);
        tick(); tick();
        rst_i = 1'b0;

        // Empty mask sinks tokens without counting them.
        drive(1'b1, 2'b00);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("mask0 ready_in", 32'(bus.ready_in_o),   32'd1);
            check("mask0 valids",   32'(bus.valids_out_o), 32'd0);
            tick();
        end
        check("mask0 cnt", 32'(token_cnt_o), 32'd0);

        // All branches ready: zero-latency acceptance.
        load_mask(2'b11);
        drive(1'b1, 2'b11); #1;
        check("full ready_in", 32'(bus.ready_in_o), 32'd1);
        tick();
        check("full cnt",     32'(token_cnt_o), 32'd1);
        check("full pending", 32'(pending_o),   32'd0);

        // Branches accept on different cycles.
        drive(1'b1, 2'b01); #1;
        check("split c0 ready_in", 32'(bus.ready_in_o),   32'd0);
        check("split c0 valids",   32'(bus.valids_out_o), 32'd3);
        tick();
        check("split c0 pending",  32'(pending_o), 32'd1);
        drive(1'b1, 2'b10); #1;
        check("split c1 valids",   32'(bus.valids_out_o), 32'd2);
        check("split c1 ready_in", 32'(bus.ready_in_o),   32'd1);
        tick();
        check("split cnt",     32'(token_cnt_o), 32'd2);
        check("split pending", 32'(pending_o),   32'd0);

        // Only branch 1 enabled, stalled for three cycles.
        load_mask(2'b10);
        drive(1'b1, 2'b00);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall valids",   32'(bus.valids_out_o), 32'd2);
            check("stall ready_in", 32'(bus.ready_in_o),   32'd0);
            tick();
        end
        drive(1'b1, 2'b10); #1;
        check("unstall ready_in", 32'(bus.ready_in_o), 32'd1);
        tick();
        check("unstall cnt", 32'(token_cnt_o), 32'd3);

        // Reconfiguration drops partial progress.
        load_mask(2'b11);
        drive(1'b1, 2'b01);
        tick();
        check("reconf pending before", 32'(pending_o), 32'd1);
        load_mask(2'b10);
        check("reconf pending after", 32'(pending_o), 32'd0);
        drive(1'b1, 2'b00); #1;
        check("reconf valids", 32'(bus.valids_out_o), 32'd2);

        // Counter wrap.
        drive(1'b1, 2'b11);
        for (int k = 0; k < 65532; k++) tick();
        check("cnt max",  32'(token_cnt_o), 32'hFFFF);
        tick();
        check("cnt wrap", 32'(token_cnt_o), 32'h0000);

        // Asynchronous reset mid-token.
        load_mask(2'b11);
        drive(1'b1, 2'b11);
        for (int k = 0; k < 5; k++) tick();
        drive(1'b1, 2'b01);
        tick();
        check("pre-rst pending", 32'(pending_o),   32'd1);
        check("pre-rst cnt",     32'(token_cnt_o), 32'd5);
        #1 rst_i = 1'b1;
        #1;
        check("async rst ready_in", 32'(bus.ready_in_o),   32'd1);
        check("async rst valids",   32'(bus.valids_out_o), 32'd0);
        check("async rst pending",  32'(pending_o),        32'd0);
        check("async rst cnt",      32'(token_cnt_o),      32'd0);
        #1 rst_i = 1'b0;
        drive(1'b1, 2'b00); #1;
        check("post-rst no reoffer", 32'(bus.valids_out_o), 32'd0);
        tick();

        // Clear wins over a coincident transfer.
        load_mask(2'b11);
        drive(1'b1, 2'b11);
        tick();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("clr cnt", 32'(token_cnt_o), 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            drive(1'($urandom_range(0, 3) != 0), N'($urandom));
            clr_i       = ($urandom_range(0, 15) == 0);
            cfg_en_i    = ($urandom_range(0, 15) == 0);
            fork_mask_i = N'($urandom);
            rst_i       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst_i = 1'b0; clr_i = 1'b0; cfg_en_i = 1'b0;
        drive(1'b0, '0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
